legv8_insn_encoder: RTL and testbench
=====================================

# legv8_insn_encoder

Instruction encoder and program loader: the inverse of the control-unit opcode decode. It accepts symbolic instructions (operation code plus register and immediate fields) over a valid/ready stream, builds 32-bit LEGv8 machine words in R/I/D/B/CB format, range-checks the immediates and writes each word to instruction memory at an auto-incrementing byte address. It sits between the test/boot host and the instruction-memory write port, ahead of the single-cycle datapath.

## Interface
- ADDR_W, 8: instruction-memory byte-address width.
- BASE_ADDR, 0: first write address after `start`; must be a multiple of 4.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load session. Honoured only in IDLE or DONE.
- in_valid  in  1  an instruction descriptor is present.
- in_ready  out  1  encoder accepts a descriptor this cycle.
- in_op  in  4  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 B, 7 CBZ, 8 CBNZ, 9 ADDI, 10 SUBI, 11 ANDI, 12 ORRI, 13 LSL, 14 LSR, 15 illegal.
- in_rd, in_rn, in_rm  in  5 each  Rd/Rt, Rn, Rm fields.
- in_imm  in  26  immediate, two's complement.
- in_last  in  1  marks the final descriptor of the session.
- mem_we  out  1  write request to instruction memory.
- mem_addr  out  ADDR_W  byte address of the write.
- mem_wdata  out  32  encoded instruction word.
- mem_ack  in  1  memory accepted the write this cycle.
- busy  out  1  high in RUN and WRITE.
- done  out  1  high in DONE, held until the next `start`.
- err  out  1  sticky; set on an illegal op, an out-of-range immediate or address overflow. Cleared by `start`.
- count  out  ADDR_W-1  number of words written this session.

## Operation
- FSM states: IDLE, RUN, WRITE, DONE. Reset places it in IDLE.
- IDLE/DONE: `start` clears `err` and `count`, sets the address to BASE_ADDR and moves to RUN. `start` in RUN or WRITE is ignored.
- RUN: `in_ready`=1. On a handshake the descriptor is encoded and registered into `mem_wdata`, and `in_last` is captured.
  - Legal descriptor: go to WRITE.
  - Illegal op or range failure: set `err` and write nothing. Go to DONE if last, otherwise stay in RUN.
- WRITE: `in_ready`=0. `mem_we`, `mem_addr` and `mem_wdata` are held stable until `mem_ack`. On ack: address += 4 and `count`++; then go to DONE if the captured last was set, otherwise back to RUN.
- Overflow: if an ack would wrap the address past 2^ADDR_W−4, set `err` and go to DONE regardless of last.
- Encodings (bit fields):
  - R (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000): op[31:21], Rm[20:16], shamt=0, Rn[9:5], Rd[4:0].
  - Shift (LSL 11010011011, LSR 11010011010): Rm=0, shamt=imm[5:0]; imm must be unsigned and below 64.
  - I (ADDI 1001000100, SUBI 1101000100, ANDI 1001001000, ORRI 1011001000): op[31:22], imm12[21:10] unsigned 0..4095.
  - D (LDUR 11111000010, STUR 11111000000): op[31:21], addr9[20:12] signed −256..255, op2[11:10]=00, Rn, Rt.
  - B (000101): imm26[25:0]; any value is legal.
  - CB (CBZ 10110100, CBNZ 10110101): op[31:24], imm19[23:5] signed, Rt[4:0].
- Range check: a signed field is legal when imm[25:N−1] are all equal to each other.

## Timing
- Reset values: `in_ready` 0, `mem_we` 0, `mem_addr` BASE_ADDR, `mem_wdata` 0, `busy` 0, `done` 0, `err` 0, `count` 0.
- Reset asserted mid-WRITE drops `mem_we` immediately, without waiting for a clock edge.
- Handshake in cycle N puts `mem_we`=1 in cycle N+1. If `mem_ack` arrives in N+1, `in_ready` is back to 1 in N+2.
- Peak throughput: one word per 2 cycles.
- `mem_ack` outside WRITE is ignored.
- `err` rises the cycle after the offending handshake.
- `done` rises the cycle after the final ack, or the cycle after the final rejected descriptor.

## Structure
- Shared package `legv8_pkg` holds the op enum, all opcode constants, field widths/offsets and the format enum (R, SHIFT, I, D, B, CB). The control unit reuses these constants.
- Sub-module `legv8_insn_encode`: purely combinational. Inputs: op and fields. Outputs: 32-bit word and a legal flag.
- The top level holds the FSM, the address/count registers and the output registers.

## Test plan
- start; ADD rd=1, rn=2, rm=3, last → one write at addr 0: 0x8B030041. Then `done`=1, `count`=1, `err`=0.
- ADDI rd=1, rn=2, imm=5, then LDUR rt=5, rn=6, imm=8, last → 0x91001441 @0, then 0xF84080C5 @4.
- B imm=−1, then CBZ rt=3, imm=2, then LSL rd=1, rn=2, imm=4, last → 0x17FFFFFF, 0xB4000043, 0xD3601041.
- LDUR imm=300, then op=15, then ADD (as in test 1), last → two rejects with `err`=1, then the ADD is written at addr 0; `count`=1.
- Hold `mem_ack` low for 5 cycles → `mem_we`/`mem_addr`/`mem_wdata` stable and `in_ready`=0 throughout. Pulse reset in the third cycle → all outputs return to reset values asynchronously.
- ADDR_W=4, BASE_ADDR=8: write 3 words → the ack at addr 12 sets `err` and enters DONE with `count`=2.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: symbolic op codes, machine opcodes, field geometry
// and immediate range helpers used by the encoder and the control unit.
package legv8_pkg;

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_AND     = 4'd2,
    OP_ORR     = 4'd3,
    OP_LDUR    = 4'd4,
    OP_STUR    = 4'd5,
    OP_B       = 4'd6,
    OP_CBZ     = 4'd7,
    OP_CBNZ    = 4'd8,
    OP_ADDI    = 4'd9,
    OP_SUBI    = 4'd10,
    OP_ANDI    = 4'd11,
    OP_ORRI    = 4'd12,
    OP_LSL     = 4'd13,
    OP_LSR     = 4'd14,
    OP_ILLEGAL = 4'd15
  } op_e;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_SHIFT,
    FMT_I,
    FMT_D,
    FMT_B,
    FMT_CB,
    FMT_NONE
  } fmt_e;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned IMM_W    = 26;
  localparam int unsigned SHAMT_W  = 6;
  localparam int unsigned I_IMM_W  = 12;
  localparam int unsigned D_ADDR_W = 9;
  localparam int unsigned CB_IMM_W = 19;

  localparam int unsigned RD_LSB    = 0;
  localparam int unsigned RN_LSB    = 5;
  localparam int unsigned SHAMT_LSB = 10;
  localparam int unsigned RM_LSB    = 16;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC_LSR  = 11'b11010011010;
  localparam logic [9:0]  OPC_ADDI = 10'b1001000100;
  localparam logic [9:0]  OPC_SUBI = 10'b1101000100;
  localparam logic [9:0]  OPC_ANDI = 10'b1001001000;
  localparam logic [9:0]  OPC_ORRI = 10'b1011001000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [7:0]  OPC_CBNZ = 8'b10110101;

  function automatic fmt_e op_format(input op_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_ORR:     return FMT_R;
      OP_LSL, OP_LSR:                     return FMT_SHIFT;
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI: return FMT_I;
      OP_LDUR, OP_STUR:                   return FMT_D;
      OP_B:                               return FMT_B;
      OP_CBZ, OP_CBNZ:                    return FMT_CB;
      default:                            return FMT_NONE;
    endcase
  endfunction

  // A signed n-bit field fits when every bit from n-1 upward equals the sign.
  function automatic logic fits_signed(input logic [IMM_W-1:0] imm, input int unsigned n);
    logic signed [IMM_W-1:0] s;
    s = $signed(imm) >>> (n - 1);
    return (s == '0) || (s == '1);
  endfunction

  function automatic logic fits_unsigned(input logic [IMM_W-1:0] imm, input int unsigned n);
    return (imm >> n) == '0;
  endfunction

endpackage

// File: rtl/legv8_insn_encode.sv
// Combinational LEGv8 word builder: packs op and fields into R/shift/I/D/B/CB
// layout and flags ops or immediates that cannot be represented.
module legv8_insn_encode
  import legv8_pkg::*;
(
  input  logic [3:0]       op_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic [REG_W-1:0] rn_i,
  input  logic [REG_W-1:0] rm_i,
  input  logic [IMM_W-1:0] imm_i,
  output logic [31:0]      word_o,
  output logic             legal_o
);

  logic [10:0] opc;
  fmt_e        fmt;

  always_comb begin
    opc = '0;
    fmt = op_format(op_e'(op_i));
    case (op_e'(op_i))
      OP_ADD:  opc = OPC_ADD;
      OP_SUB:  opc = OPC_SUB;
      OP_AND:  opc = OPC_AND;
      OP_ORR:  opc = OPC_ORR;
      OP_LSL:  opc = OPC_LSL;
      OP_LSR:  opc = OPC_LSR;
      OP_LDUR: opc = OPC_LDUR;
      OP_STUR: opc = OPC_STUR;
      OP_ADDI: opc = {1'b0, OPC_ADDI};
      OP_SUBI: opc = {1'b0, OPC_SUBI};
      OP_ANDI: opc = {1'b0, OPC_ANDI};
      OP_ORRI: opc = {1'b0, OPC_ORRI};
      OP_CBZ:  opc = {3'b000, OPC_CBZ};
      OP_CBNZ: opc = {3'b000, OPC_CBNZ};
      default: opc = '0;
    endcase
  end

  // Narrow opcodes sit right-aligned in opc; each format slices what it needs.
  always_comb begin
    word_o  = '0;
    legal_o = 1'b0;
    case (fmt)
      FMT_R: begin
        word_o  = {opc, rm_i, 6'b000000, rn_i, rd_i};
        legal_o = 1'b1;
      end
      FMT_SHIFT: begin
        word_o  = {opc, 5'b00000, imm_i[SHAMT_W-1:0], rn_i, rd_i};
        legal_o = fits_unsigned(imm_i, SHAMT_W);
      end
      FMT_I: begin
        word_o  = {opc[9:0], imm_i[I_IMM_W-1:0], rn_i, rd_i};
        legal_o = fits_unsigned(imm_i, I_IMM_W);
      end
      FMT_D: begin
        word_o  = {opc, imm_i[D_ADDR_W-1:0], 2'b00, rn_i, rd_i};
        legal_o = fits_signed(imm_i, D_ADDR_W);
      end
      FMT_B: begin
        word_o  = {OPC_B, imm_i};
        legal_o = 1'b1;
      end
      FMT_CB: begin
        word_o  = {opc[7:0], imm_i[CB_IMM_W-1:0], rd_i};
        legal_o = fits_signed(imm_i, CB_IMM_W);
      end
      default: begin
        word_o  = '0;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/legv8_insn_encoder.sv
// Program loader: accepts symbolic instructions on a valid/ready stream, encodes
// them and writes each word to instruction memory at consecutive word addresses.
module legv8_insn_encoder
  import legv8_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [25:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-2:0] count,
  output logic [1:0]        dbg_state
);

  // Stream handshake: a descriptor transfers on a rising edge where in_valid and
  // in_ready are both high; a memory write completes on an edge with mem_we and mem_ack.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {{(ADDR_W-2){1'b1}}, 2'b00};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-2:0] count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              last_q, last_d;

  logic [31:0] enc_word;
  logic        enc_legal;

  legv8_insn_encode u_encode (
    .op_i    (in_op),
    .rd_i    (in_rd),
    .rn_i    (in_rn),
    .rm_i    (in_rm),
    .imm_i   (in_imm),
    .word_o  (enc_word),
    .legal_o (enc_legal)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d   = 1'b0;
          count_d = '0;
          addr_d  = BASE_ADDR;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          wdata_d = enc_word;
          last_d  = in_last;
          if (enc_legal) begin
            state_d = S_WRITE;
          end else begin
            err_d   = 1'b1;
            state_d = in_last ? S_DONE : S_RUN;
          end
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          count_d = count_q + 1'b1;
          // The top word of memory was just filled; there is nowhere left to go.
          if (addr_q == LAST_ADDR) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(4);
            state_d = last_q ? S_DONE : S_RUN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  assign in_ready  = (state_q == S_RUN);
  assign mem_we    = (state_q == S_WRITE);
  assign busy      = (state_q == S_RUN) || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign err       = err_q;
  assign count     = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_legv8_insn_encoder.sv
// Bench for legv8_insn_encoder: directed and random descriptors checked against
// an arithmetic encoding model, plus reset and address-overflow scenarios.
module tb_legv8_insn_encoder;

  logic        clk;
  logic        reset;
  logic        start, in_valid, in_last, mem_ack;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rn, in_rm;
  logic [25:0] in_imm;
  logic        in_ready, mem_we, busy, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0]  count;
  logic [1:0]  dbg_state;

  logic        start2, in_valid2, mem_ack2;
  logic        in_ready2, mem_we2, busy2, done2, err2;
  logic [3:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [2:0]  count2;
  logic [1:0]  dbg_state2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  exp_addr_q[$];
  logic [7:0]  m_addr;
  int          m_count;
  bit          m_err;

  // Opcode bit patterns indexed by symbolic op, each at its own width.
  longint unsigned opc_tab[16] = '{
    'b10001011000, 'b11001011000, 'b10001010000, 'b10101010000,
    'b11111000010, 'b11111000000, 'b000101,      'b10110100,
    'b10110101,    'b1001000100,  'b1101000100,  'b1001001000,
    'b1011001000,  'b11010011011, 'b11010011010, 0
  };

  legv8_insn_encoder #(.ADDR_W(8), .BASE_ADDR(8'd0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .busy(busy), .done(done), .err(err), .count(count),
    .dbg_state(dbg_state)
  );

  legv8_insn_encoder #(.ADDR_W(4), .BASE_ADDR(4'd8)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .in_last(in_last), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_ack(mem_ack2), .busy(busy2), .done(done2), .err(err2), .count(count2),
    .dbg_state(dbg_state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $error("FAIL watchdog: observed timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Encoding straight from the field rules, using integer arithmetic.
  function automatic void ref_enc(input int op, input int rd, input int rn, input int rm,
                                  input logic [25:0] imm, output bit legal,
                                  output logic [31:0] w);
    longint s, u, r;
    s = longint'($signed(imm));
    u = longint'(imm);
    legal = 1;
    r = 0;
    if (op <= 3) begin
      r = opc_tab[op] * 2**21 + rm * 65536 + rn * 32 + rd;
    end else if (op == 4 || op == 5) begin
      legal = (s >= -256) && (s <= 255);
      r = opc_tab[op] * 2**21 + ((s + 512) % 512) * 4096 + rn * 32 + rd;
    end else if (op == 6) begin
      r = 5 * 2**26 + u;
    end else if (op == 7 || op == 8) begin
      legal = (s >= -262144) && (s <= 262143);
      r = opc_tab[op] * 2**24 + ((s + 524288) % 524288) * 32 + rd;
    end else if (op >= 9 && op <= 12) begin
      legal = (u <= 4095);
      r = opc_tab[op] * 2**22 + u * 1024 + rn * 32 + rd;
    end else if (op == 13 || op == 14) begin
      legal = (u < 64);
      r = opc_tab[op] * 2**21 + u * 1024 + rn * 32 + rd;
    end else begin
      legal = 0;
    end
    w = r[31:0];
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_addr = 8'd0;
    m_count = 0;
    m_err = 0;
    check("start_busy", busy, 1);
    check("start_err", err, 0);
    check("start_count", count, 0);
  endtask

  task automatic send(input int op, input int rd, input int rn, input int rm,
                      input logic [25:0] imm, input bit last);
    bit          legal;
    logic [31:0] w, ew;
    logic [7:0]  ea;
    int          d, waits;
    ref_enc(op, rd, rn, rm, imm, legal, w);
    in_valid = 1'b1;
    in_op = 4'(op);
    in_rd = 5'(rd);
    in_rn = 5'(rn);
    in_rm = 5'(rm);
    in_imm = imm;
    in_last = last;
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check("in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    if (legal) begin
      exp_q.push_back(w);
      exp_addr_q.push_back(m_addr);
      ew = exp_q.pop_front();
      ea = exp_addr_q.pop_front();
      check("mem_we", mem_we, 1);
      check("mem_wdata", mem_wdata, ew);
      check("mem_addr", mem_addr, ea);
      d = $urandom_range(0, 2);
      for (int i = 0; i < d; i++) begin
        @(negedge clk);
        check("hold_ready", in_ready, 0);
        check("hold_we", mem_we, 1);
        check("hold_wdata", mem_wdata, ew);
        check("hold_addr", mem_addr, ea);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      m_addr = m_addr + 8'd4;
      m_count++;
      if (!last) check("ready_after_ack", in_ready, 1);
    end else begin
      m_err = 1;
      check("reject_err", err, 1);
      check("reject_we", mem_we, 0);
    end
    if (last) begin
      check("last_done", done, 1);
      check("last_count", count, 32'(m_count));
      check("last_err", err, 32'(m_err));
      check("last_busy", busy, 0);
    end
  endtask

  function automatic logic [25:0] rand_imm();
    logic [25:0] t;
    case ($urandom_range(0, 3))
      0: t = 26'($urandom_range(0, 300));
      1: begin t = 26'($urandom_range(1, 300)); t = -t; end
      2: t = 26'($urandom);
      default: t = 26'($urandom_range(4000, 4200));
    endcase
    return t;
  endfunction

  initial begin
    logic [31:0] held_wdata;
    int          n;
    reset = 1'b1;
    start = 0; in_valid = 0; in_last = 0; mem_ack = 0;
    start2 = 0; in_valid2 = 0; mem_ack2 = 0;
    in_op = 0; in_rd = 0; in_rn = 0; in_rm = 0; in_imm = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_count", count, 0);
    check("rst_addr2", mem_addr2, 8);
    reset = 1'b0;

    do_start();
    send(0, 1, 2, 3, 26'd0, 1);

    do_start();
    send(9, 1, 2, 0, 26'd5, 0);
    send(4, 5, 6, 0, 26'd8, 1);

    do_start();
    send(6, 0, 0, 0, 26'h3FFFFFF, 0);
    send(7, 3, 0, 0, 26'd2, 0);
    send(13, 1, 2, 0, 26'd4, 1);

    do_start();
    send(4, 1, 1, 0, 26'd300, 0);
    send(15, 1, 2, 3, 26'd0, 0);
    send(0, 1, 2, 3, 26'd0, 1);

    // Immediate boundaries on each checked format.
    do_start();
    send(4, 7, 8, 0, 26'd255, 0);
    send(5, 7, 8, 0, -26'd256, 0);
    send(4, 7, 8, 0, 26'd256, 0);
    send(5, 7, 8, 0, -26'd257, 0);
    send(10, 4, 9, 0, 26'd4095, 0);
    send(11, 4, 9, 0, 26'd4096, 0);
    send(14, 2, 3, 0, 26'd63, 0);
    send(13, 2, 3, 0, 26'd64, 0);
    send(8, 31, 0, 0, 26'd262143, 0);
    send(7, 31, 0, 0, -26'd262144, 0);
    send(8, 31, 0, 0, 26'd262144, 1);

    // An ack while in RUN must not count as a write.
    do_start();
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray_ack_count", count, 0);
    check("stray_ack_ready", in_ready, 1);
    send(1, 9, 10, 11, 26'd0, 1);

    for (int s = 0; s < 6; s++) begin
      do_start();
      n = $urandom_range(2, 7);
      for (int k = 0; k < n; k++)
        send($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), rand_imm(), k == n - 1);
    end

    // Stalled write, then asynchronous reset partway through the stall.
    do_start();
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd2; in_rd = 5'd4; in_rn = 5'd5; in_rm = 5'd6; in_last = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    held_wdata = mem_wdata;
    check("stall_we0", mem_we, 1);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("stall_we", mem_we, 1);
      check("stall_ready", in_ready, 0);
      check("stall_wdata", mem_wdata, held_wdata);
      check("stall_addr", mem_addr, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_we", mem_we, 0);
    check("async_ready", in_ready, 0);
    check("async_wdata", mem_wdata, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_count", count, 0);
    @(negedge clk);
    reset = 1'b0;

    // Narrow instance: the write into the top word overflows the address.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    in_op = 4'd0; in_rd = 5'd1; in_rn = 5'd2; in_rm = 5'd3; in_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid2 = 1'b1;
      if (k == 1) check("ov_err_mid", err2, 0);
      check("ov_ready", in_ready2, (k < 2) ? 1 : 0);
      @(negedge clk);
      in_valid2 = 1'b0;
      if (k < 2) begin
        check("ov_we", mem_we2, 1);
        check("ov_addr", mem_addr2, 8 + 4 * k);
        mem_ack2 = 1'b1;
        @(negedge clk);
        mem_ack2 = 1'b0;
      end
    end
    check("ov_err", err2, 1);
    check("ov_done", done2, 1);
    check("ov_count", count2, 2);
    check("ov_we_off", mem_we2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
